// File: rtl/fuzzy_sweep_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module : fuzzy_pkg
// Brief  : Shared widths, sweep FSM state encoding and index clamp helper.
// Rev    : 1.0
// ============================================================================
package fuzzy_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_IDX_W  = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_PUSH    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    // Comparison happens on the full 9-bit index so 255/256 clamp correctly.
    function automatic logic [c_DATA_W-1:0] clamp_idx(
        input logic [c_IDX_W-1:0] x,
        input logic [c_IDX_W-1:0] lo,
        input logic [c_IDX_W-1:0] hi
    );
        logic [c_IDX_W-1:0] v;
        v = x;
        if (x < lo) begin
            v = lo;
        end else if (x > hi) begin
            v = hi;
        end
        return v[c_DATA_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fuzzy_sweep_capture_if.sv
`default_nettype none
// ============================================================================
// Module : fuzzy_sweep_capture_if
// Brief  : Sample stream (valid/ready) carrying captured data and grid indices.
// Rev    : 1.0
// ============================================================================
interface fuzzy_sweep_capture_if;
    import fuzzy_pkg::*;

    logic                out_valid;
    logic                out_ready;
    logic [c_DATA_W-1:0] out_data;
    logic [c_IDX_W-1:0]  out_i;
    logic [c_IDX_W-1:0]  out_j;
    logic                out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_i,
        output out_j,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_i,
        input  out_j,
        input  out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/fuzzy_sweep_capture_grid_counter.sv
`default_nettype none
// ============================================================================
// Module : fuzzy_grid_counter
// Brief  : Nested i/j step counter (j fastest) with final-point flag.
// Rev    : 1.0
// ============================================================================
module fuzzy_grid_counter
    import fuzzy_pkg::*;
#(
    parameter int STEP  = 16,
    parameter int LIMIT = 256
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_clear,
    input  wire logic               i_advance,
    output logic [c_IDX_W-1:0]      o_idx_i,
    output logic [c_IDX_W-1:0]      o_idx_j,
    output logic                    o_last
);

    localparam int                 c_N      = LIMIT / STEP + 1;
    localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'((c_N - 1) * STEP);
    localparam logic [c_IDX_W:0]   c_STEP10 = (c_IDX_W + 1)'(STEP);
    localparam logic [c_IDX_W:0]   c_LIM10  = (c_IDX_W + 1)'(LIMIT);

    logic [c_IDX_W-1:0] r_i;
    logic [c_IDX_W-1:0] r_j;
    logic [c_IDX_W:0]   w_i_next;
    logic [c_IDX_W:0]   w_j_next;

    // One extra bit so j+STEP past LIMIT is seen rather than wrapping.
    assign w_i_next = {1'b0, r_i} + c_STEP10;
    assign w_j_next = {1'b0, r_j} + c_STEP10;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_advance) begin
            if (w_j_next > c_LIM10) begin
                r_j <= '0;
                r_i <= w_i_next[c_IDX_W-1:0];
            end else begin
                r_j <= w_j_next[c_IDX_W-1:0];
            end
        end
    end

    assign o_idx_i = r_i;
    assign o_idx_j = r_j;
    assign o_last  = (r_i == c_LAST) && (r_j == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fuzzy_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module : fuzzy_sweep_capture
// Brief  : Sweeps the fuzzy core inputs over a 2-D grid, settles, samples the
//          defuzzified output and streams each sample with its indices.
// Rev    : 1.0
// ============================================================================
module fuzzy_sweep_capture
    import fuzzy_pkg::*;
#(
    parameter int STEP          = 16,
    parameter int LIMIT         = 256,
    parameter int IN_MIN        = 1,
    parameter int IN_MAX        = 254,
    parameter int SETTLE_CYCLES = 14
) (
    input  wire logic                clk_0,
    input  wire logic                Srst,
    input  wire logic                start,
    output logic                     busy,
    output logic                     done,
    output logic [c_DATA_W-1:0]      Entrada_01,
    output logic [c_DATA_W-1:0]      Entrada_02,
    output logic                     EN_REGRAS,
    input  wire logic [c_DATA_W-1:0] saida_defuzzy,
    fuzzy_sweep_capture_if.master    strm
);

    localparam int                  c_CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]  c_SETTLE  = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]  c_IN_MIN  = c_IDX_W'(IN_MIN);
    localparam logic [c_IDX_W-1:0]  c_IN_MAX  = c_IDX_W'(IN_MAX);
    localparam logic [c_DATA_W-1:0] c_RST_IN  = c_DATA_W'(IN_MIN);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_settle;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_en;
    logic [c_DATA_W-1:0]  r_in1;
    logic [c_DATA_W-1:0]  r_in2;
    logic                 r_valid;
    logic [c_DATA_W-1:0]  r_data;
    logic [c_IDX_W-1:0]   r_oi;
    logic [c_IDX_W-1:0]   r_oj;
    logic                 r_last;

    logic                 w_clear;
    logic                 w_advance;
    logic [c_IDX_W-1:0]   w_i;
    logic [c_IDX_W-1:0]   w_j;
    logic                 w_grid_last;

    assign w_clear   = (r_state == ST_IDLE) && start;
    assign w_advance = (r_state == ST_ADVANCE);

    fuzzy_grid_counter #(
        .STEP  (STEP),
        .LIMIT (LIMIT)
    ) u_grid (
        .clk       (clk_0),
        .rst       (Srst),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_idx_i   (w_i),
        .o_idx_j   (w_j),
        .o_last    (w_grid_last)
    );

    always_ff @(posedge clk_0) begin
        if (Srst) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_en     <= 1'b0;
            r_in1    <= c_RST_IN;
            r_in2    <= c_RST_IN;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_oi     <= '0;
            r_oj     <= '0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_en    <= 1'b1;
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_in1    <= clamp_idx(w_i, c_IN_MIN, c_IN_MAX);
                    r_in2    <= clamp_idx(w_j, c_IN_MIN, c_IN_MAX);
                    r_settle <= c_SETTLE;
                    r_state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Sample lands exactly SETTLE_CYCLES edges after the input update.
                    if (r_settle == '0) begin
                        r_data  <= saida_defuzzy;
                        r_oi    <= w_i;
                        r_oj    <= w_j;
                        r_last  <= w_grid_last;
                        r_valid <= 1'b1;
                        r_state <= ST_PUSH;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                ST_PUSH: begin
                    if (strm.out_ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            r_busy  <= 1'b0;
                            r_en    <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_ADVANCE;
                        end
                    end
                end
                ST_ADVANCE: begin
                    r_state <= ST_APPLY;
                end
                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign EN_REGRAS      = r_en;
    assign Entrada_01     = r_in1;
    assign Entrada_02     = r_in2;
    assign strm.out_valid = r_valid;
    assign strm.out_data  = r_data;
    assign strm.out_i     = r_oi;
    assign strm.out_j     = r_oj;
    assign strm.out_last  = r_last;

endmodule
`default_nettype wire
